// File: rtl/pe_ctrl_pkg.sv
// Shared types for the PE sequencer: FSM state encoding and counter widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pe_ctrl_pkg;

    localparam int GRP_W  = 2;  // filter group index, 4 groups of 4 bytes
    localparam int TAP_W  = 4;  // filter tap index, up to 16 taps
    localparam int BYTE_W = 2;  // byte position inside the packed output word
    localparam int ADDR_W = 8;  // output-memory address / word counter width

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CLR,
        MAC,
        SHIFT,
        FINAL,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/pe_seq_counters.sv
// Index counters for the PE sequencer: filter group, tap, byte, word and output address.
// Latency: every inc/clear takes effect on the next clock edge.
// Backpressure: none; the FSM only pulses inc when the matching beat really happens.
module pe_seq_counters
    import pe_ctrl_pkg::*;
#(
    parameter int Z_BASE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_all,
    input  logic              grp_inc,
    input  logic              tap_clr,
    input  logic              tap_inc,
    input  logic              byte_inc,
    input  logic              word_inc,
    output logic [GRP_W-1:0]  grp,
    output logic [TAP_W-1:0]  tap,
    output logic [BYTE_W-1:0] byte_idx,
    output logic [ADDR_W-1:0] word,
    output logic [ADDR_W-1:0] z
);

    localparam logic [ADDR_W-1:0] Z_INIT = ADDR_W'(Z_BASE);

    // Counters advance only on their own strobe; clr_all rewinds everything for a new run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grp      <= '0;
            tap      <= '0;
            byte_idx <= '0;
            word     <= '0;
            z        <= Z_INIT;
        end else if (clr_all) begin
            grp      <= '0;
            tap      <= '0;
            byte_idx <= '0;
            word     <= '0;
            z        <= Z_INIT;
        end else begin
            if (grp_inc) begin
                grp <= grp + 1'b1;
            end
            if (tap_clr) begin
                tap <= '0;
            end else if (tap_inc) begin
                tap <= tap + 1'b1;
            end
            if (byte_inc) begin
                byte_idx <= byte_idx + 1'b1;
            end
            // The address moves together with the word count, after the write cycle.
            if (word_inc) begin
                word <= word + 1'b1;
                z    <= z + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pe_sequencer.sv
// Sequences one PE: filter load, MAC accumulate, shift packing and output-memory write-back.
// Latency: 4 load cycles + NUM_WORDS*(4*(FILT_LEN+2)+2) cycles + 1 from start to done.
// Backpressure: filt_valid low stalls LOAD, win_valid low stalls MAC; counters hold while stalled.
module pe_sequencer
    import pe_ctrl_pkg::*;
#(
    parameter int FILT_LEN  = 16,
    parameter int NUM_WORDS = 43,
    parameter int Z_BASE    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              filt_valid,
    input  logic              win_valid,
    output logic              win_ready,
    output logic              busy,
    output logic              write_filter_buff_en,
    output logic [GRP_W-1:0]  write_filter_buff_ind,
    output logic [TAP_W-1:0]  read_four_to_four_buff_ind,
    output logic              reset_mac,
    output logic              partial_res_en,
    output logic              shift_reg_en,
    output logic              finalize_shift_reg,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] z_out,
    output logic              done
);

    // Elaboration-time guards on the parameter ranges.
    if (FILT_LEN < 1 || FILT_LEN > 16) begin : g_bad_filt_len
        $error("pe_sequencer: FILT_LEN must be in 1..16");
    end
    if (NUM_WORDS < 1 || Z_BASE < 0 || Z_BASE + NUM_WORDS - 1 > 255) begin : g_bad_addr_range
        $error("pe_sequencer: Z_BASE+NUM_WORDS-1 must fit in 0..255");
    end

    localparam logic [TAP_W-1:0]  TAP_LAST  = TAP_W'(FILT_LEN - 1);
    localparam logic [ADDR_W-1:0] WORD_LAST = ADDR_W'(NUM_WORDS - 1);

    state_t              state, state_next;
    logic                clr_all, grp_inc, tap_clr, tap_inc, byte_inc, word_inc;
    logic [GRP_W-1:0]    grp;
    logic [TAP_W-1:0]    tap;
    logic [BYTE_W-1:0]   byte_idx;
    logic [ADDR_W-1:0]   word;

    pe_seq_counters #(
        .Z_BASE (Z_BASE)
    ) u_counters (
        .clk      (clk),
        .rst      (rst),
        .clr_all  (clr_all),
        .grp_inc  (grp_inc),
        .tap_clr  (tap_clr),
        .tap_inc  (tap_inc),
        .byte_inc (byte_inc),
        .word_inc (word_inc),
        .grp      (grp),
        .tap      (tap),
        .byte_idx (byte_idx),
        .word     (word),
        .z        (z_out)
    );

    assign write_filter_buff_ind      = grp;
    assign read_four_to_four_buff_ind = tap;
    assign win_ready                  = partial_res_en;

    // State register; reset aborts a run immediately, so no half-finished write can follow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, counter controls and strobes. Only the LOAD write and the MAC beat are
    // qualified by their valid input; everything else decodes purely from registers.
    always_comb begin
        state_next           = state;
        clr_all              = 1'b0;
        grp_inc              = 1'b0;
        tap_clr              = 1'b0;
        tap_inc              = 1'b0;
        byte_inc             = 1'b0;
        word_inc             = 1'b0;
        write_filter_buff_en = 1'b0;
        reset_mac            = 1'b0;
        partial_res_en       = 1'b0;
        shift_reg_en         = 1'b0;
        finalize_shift_reg   = 1'b0;
        mem_write_en         = 1'b0;
        done                 = 1'b0;
        busy                 = (state != IDLE) && (state != DONE);
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (filt_valid) begin
                    write_filter_buff_en = 1'b1;
                    grp_inc              = 1'b1;
                    if (grp == GRP_W'(3)) begin
                        state_next = CLR;
                    end
                end
            end
            CLR: begin
                reset_mac  = 1'b1;
                tap_clr    = 1'b1;
                state_next = MAC;
            end
            MAC: begin
                if (win_valid) begin
                    partial_res_en = 1'b1;
                    tap_inc        = 1'b1;
                    if (tap == TAP_LAST) begin
                        state_next = SHIFT;
                    end
                end
            end
            SHIFT: begin
                shift_reg_en = 1'b1;
                byte_inc     = 1'b1;
                state_next   = (byte_idx == BYTE_W'(3)) ? FINAL : CLR;
            end
            FINAL: begin
                finalize_shift_reg = 1'b1;
                state_next         = WRITE;
            end
            WRITE: begin
                mem_write_en = 1'b1;
                word_inc     = 1'b1;
                state_next   = (word == WORD_LAST) ? DONE : CLR;
            end
            DONE: begin
                done = 1'b1;
                // A held start never re-triggers; start must drop before the next run.
                if (!start) begin
                    clr_all    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
